// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among NUM_REQ byte sources
//
// Purpose:
//   Picks one requester holding a byte, latches its byte onto tx_data, pulses
//   its req_ready, then pulses tx_start and keeps ownership of the transmitter
//   until tx_done_tick ends the frame.
//   Default build selects round-robin. Defining UART_ARB_FIXED_PRIORITY_EN
//   selects fixed priority (lowest index wins, no round-robin pointer).
//
// Ports:
//   clk_50MHz     in   system clock
//   reset         in   asynchronous active-low reset
//   req_valid     in   [NUM_REQ]            requester i holds a byte
//   req_data      in   [NUM_REQ*DATA_BITS]  byte i at [i*DATA_BITS +: DATA_BITS]
//   req_ready     out  [NUM_REQ]            one-cycle accept pulse for requester i
//   tx_start      out                       one-cycle start pulse to the transmitter
//   tx_data       out  [DATA_BITS]          byte for the transmitter, held until next grant
//   tx_busy       in                        transmitter busy
//   tx_done_tick  in                        transmitter end-of-frame pulse
//   grant_id      out  [ID_BITS]            index of current/last granted requester
//   arb_busy      out                       high whenever the FSM is not IDLE

module uart_tx_arbiter #(
   parameter int DATA_BITS = 8,
   parameter int NUM_REQ   = 2,
   parameter int ID_BITS   = 1
) (
   input  logic                         clk_50MHz,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic                         tx_start,
   output logic [DATA_BITS-1:0]         tx_data,
   input  logic                         tx_busy,
   input  logic                         tx_done_tick,
   output logic [ID_BITS-1:0]           grant_id,
   output logic                         arb_busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   grant;
   logic                   found;
   logic [ID_BITS-1:0]     win_id;
   logic [NUM_REQ-1:0]     win_onehot;
   logic [DATA_BITS-1:0]   win_data;

`ifdef UART_ARB_FIXED_PRIORITY_EN
   // Descending scan: the last hit written is the lowest valid index.
   always_comb begin
      found      = 1'b0;
      win_id     = '0;
      win_onehot = '0;
      win_data   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            found      = 1'b1;
            win_id     = ID_BITS'(i);
            win_onehot = NUM_REQ'(1) << i;
            win_data   = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end
`else
   logic [ID_BITS-1:0] rr_ptr;

   // Two descending scans: the first covers indices below the pointer (the
   // wrapped-around part of the search), the second covers indices at or
   // above it and overrides, so the first valid index from rr_ptr upward
   // wins and only otherwise the lowest index below rr_ptr.
   always_comb begin
      found      = 1'b0;
      win_id     = '0;
      win_onehot = '0;
      win_data   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i < int'(rr_ptr))) begin
            found      = 1'b1;
            win_id     = ID_BITS'(i);
            win_onehot = NUM_REQ'(1) << i;
            win_data   = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i] && (i >= int'(rr_ptr))) begin
            found      = 1'b1;
            win_id     = ID_BITS'(i);
            win_onehot = NUM_REQ'(1) << i;
            win_data   = req_data[i*DATA_BITS +: DATA_BITS];
         end
      end
   end

   always_ff @(posedge clk_50MHz or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (win_id == ID_BITS'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk_50MHz or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            // A busy transmitter is owned elsewhere; tx_done_tick is ignored here.
            if (found && !tx_busy) begin
               grant     = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            state_nxt = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // A frame may already be over before busy was ever seen.
            if (tx_done_tick) begin
               state_nxt = IDLE;
            end else if (tx_busy) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done_tick) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered outputs: ready is seen the cycle after the grant decision,
   // tx_start one cycle after ready.
   always_ff @(posedge clk_50MHz or negedge reset) begin
      if (!reset) begin
         req_ready <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         grant_id  <= '0;
      end else begin
         req_ready <= grant ? win_onehot : '0;
         tx_start  <= (state == START);
         if (grant) begin
            tx_data  <= win_data;
            grant_id <= win_id;
         end
      end
   end

   assign arb_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

   localparam int N = 3;

   logic          clk_50MHz;
   logic          reset;
   logic [N-1:0]  req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic          tx_done_tick;
   logic [1:0]    grant_id;
   logic          arb_busy;

   logic [7:0]    data [N];
   int            ptr;
   int            n_checks;
   int            n_fail;

   assign req_data = {data[2], data[1], data[0]};

   uart_tx_arbiter #(
      .DATA_BITS (8),
      .NUM_REQ   (N),
      .ID_BITS   (2)
   ) dut (
      .clk_50MHz    (clk_50MHz),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .tx_done_tick (tx_done_tick),
      .grant_id     (grant_id),
      .arb_busy     (arb_busy)
   );

   initial clk_50MHz = 1'b0;
   always #10 clk_50MHz = ~clk_50MHz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference winner: search order from the pointer (or from 0 in fixed priority).
   function automatic int model_pick(input logic [N-1:0] v);
      int vi;
      int idx;
      vi = int'(v);
      for (int k = 0; k < N; k++) begin
`ifdef UART_ARB_FIXED_PRIORITY_EN
         idx = k;
`else
         idx = (ptr + k) % N;
`endif
         if (((vi >> idx) & 1) != 0) return idx;
      end
      return -1;
   endfunction

   task automatic check_idle(input string tag);
      chk({tag, " ready"}, 32'(req_ready), 32'd0);
      chk({tag, " start"}, 32'(tx_start), 32'd0);
      chk({tag, " busy"}, 32'(arb_busy), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk_50MHz); #1;
      reset = 1'b0;
      tx_busy = 1'b0;
      tx_done_tick = 1'b0;
      #2;
      chk({tag, " rst ready"}, 32'(req_ready), 32'd0);
      chk({tag, " rst start"}, 32'(tx_start), 32'd0);
      chk({tag, " rst data"}, 32'(tx_data), 32'd0);
      chk({tag, " rst gid"}, 32'(grant_id), 32'd0);
      chk({tag, " rst busy"}, 32'(arb_busy), 32'd0);
      @(posedge clk_50MHz); #1;
      reset = 1'b1;
      ptr = 0;
   endtask

   // One full frame starting with a grant at the next edge.
   // mode 0: requester drops valid after ready; 1: keeps same byte; 2: new random byte.
   task automatic frame(input string tag, input bit early_done, input int busy_len, input int mode);
      int         w;
      logic [1:0] wi;
      logic [7:0] d;
      w = model_pick(req_valid);
      if (w < 0) begin
         chk({tag, " no requester in frame"}, 32'd1, 32'd0);
         return;
      end
      wi = 2'(w);
      d  = data[wi];
      @(posedge clk_50MHz); #1;
      chk({tag, " ready"}, 32'(req_ready), 32'(1) << w);
      chk({tag, " gid"}, 32'(grant_id), 32'(w));
      chk({tag, " data"}, 32'(tx_data), 32'(d));
      chk({tag, " start early"}, 32'(tx_start), 32'd0);
      ptr = (w + 1) % N;
      if (mode == 0) req_valid[wi] = 1'b0;
      else if (mode == 2) data[wi] = 8'($urandom);
      @(posedge clk_50MHz); #1;
      chk({tag, " start"}, 32'(tx_start), 32'd1);
      chk({tag, " ready gone"}, 32'(req_ready), 32'd0);
      chk({tag, " data hold"}, 32'(tx_data), 32'(d));
      if (early_done) begin
         tx_done_tick = 1'b1;
         @(posedge clk_50MHz); #1;
         tx_done_tick = 1'b0;
         chk({tag, " early idle"}, 32'(arb_busy), 32'd0);
         chk({tag, " early start"}, 32'(tx_start), 32'd0);
      end else begin
         tx_busy = 1'b1;
         repeat (busy_len) begin
            @(posedge clk_50MHz); #1;
            chk({tag, " wd start"}, 32'(tx_start), 32'd0);
            chk({tag, " wd ready"}, 32'(req_ready), 32'd0);
            chk({tag, " wd busy"}, 32'(arb_busy), 32'd1);
            chk({tag, " wd data"}, 32'(tx_data), 32'(d));
         end
         tx_done_tick = 1'b1;
         tx_busy = 1'b0;
         @(posedge clk_50MHz); #1;
         tx_done_tick = 1'b0;
         chk({tag, " done idle"}, 32'(arb_busy), 32'd0);
         chk({tag, " gid hold"}, 32'(grant_id), 32'(w));
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      ptr = 0;
      reset = 1'b0;
      req_valid = '0;
      tx_busy = 1'b0;
      tx_done_tick = 1'b0;
      for (int i = 0; i < N; i++) data[i] = 8'h00;

      // Reset state
      #3;
      chk("reset ready", 32'(req_ready), 32'd0);
      chk("reset start", 32'(tx_start), 32'd0);
      chk("reset data", 32'(tx_data), 32'd0);
      chk("reset gid", 32'(grant_id), 32'd0);
      chk("reset busy", 32'(arb_busy), 32'd0);
      @(posedge clk_50MHz); #1;
      reset = 1'b1;

      // Single requester
      data[0] = 8'h41;
      req_valid = 3'b001;
      frame("t1", 1'b0, 2, 0);
      check_idle("t1 after");

      // Two requesters held: round-robin alternates, fixed priority repeats 0
      do_reset("t2");
      data[0] = 8'h41;
      data[1] = 8'h42;
      req_valid = 3'b011;
      frame("t2a", 1'b0, 3, 1);
      frame("t2b", 1'b0, 1, 0);
      req_valid = '0;

      // Transmitter busy elsewhere holds off the grant
      data[1] = 8'h5a;
      req_valid = 3'b010;
      tx_busy = 1'b1;
      repeat (4) begin
         @(posedge clk_50MHz); #1;
         check_idle("t3 blocked");
      end
      tx_busy = 1'b0;
      frame("t3", 1'b0, 2, 0);

      // Done tick in IDLE is ignored; done tick in WAIT_BUSY returns to IDLE
      tx_done_tick = 1'b1;
      @(posedge clk_50MHz); #1;
      tx_done_tick = 1'b0;
      check_idle("t4 idle done");
      @(posedge clk_50MHz); #1;
      check_idle("t4 idle done2");
      data[2] = 8'hc3;
      req_valid = 3'b100;
      frame("t4", 1'b1, 0, 0);
      check_idle("t4 after");

      // Reset asserted in WAIT_DONE
      data[0] = 8'h77;
      req_valid = 3'b001;
      @(posedge clk_50MHz); #1;
      req_valid = '0;
      @(posedge clk_50MHz); #1;
      tx_busy = 1'b1;
      @(posedge clk_50MHz); #1;
      chk("t5 in wait", 32'(arb_busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t5 rst ready", 32'(req_ready), 32'd0);
      chk("t5 rst start", 32'(tx_start), 32'd0);
      chk("t5 rst data", 32'(tx_data), 32'd0);
      chk("t5 rst gid", 32'(grant_id), 32'd0);
      chk("t5 rst busy", 32'(arb_busy), 32'd0);
      tx_busy = 1'b0;
      ptr = 0;
      @(posedge clk_50MHz); #1;
      reset = 1'b1;
      data[0] = 8'h31;
      req_valid = 3'b001;
      frame("t5", 1'b0, 2, 0);

      // Three requesters, four frames: pointer wraps 2 -> 0
      do_reset("t6");
      data[0] = 8'h10;
      data[1] = 8'h11;
      data[2] = 8'h12;
      req_valid = 3'b111;
      frame("t6a", 1'b0, 1, 1);
      frame("t6b", 1'b0, 1, 1);
      frame("t6c", 1'b0, 1, 1);
      frame("t6d", 1'b0, 1, 1);
      req_valid = '0;

      // Randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < N; i++) begin
            logic [1:0] ii;
            ii = 2'(i);
            if (!req_valid[ii] && ($urandom_range(1, 0) == 1)) begin
               req_valid[ii] = 1'b1;
               data[ii] = 8'($urandom);
            end
         end
         if (req_valid == '0) begin
            @(posedge clk_50MHz); #1;
            check_idle("rnd idle");
            continue;
         end
         if ($urandom_range(3, 0) == 0) begin
            tx_busy = 1'b1;
            repeat ($urandom_range(3, 1)) begin
               @(posedge clk_50MHz); #1;
               check_idle("rnd blocked");
            end
            tx_busy = 1'b0;
         end
         frame("rnd", ($urandom_range(4, 0) == 0), int'($urandom_range(4, 1)),
               ($urandom_range(1, 0) == 1) ? 2 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
